instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage for the single-cycle datapath: holds the PC, drives instruction-memory address,
//  splits the 16-bit instruction into opcode/register/immediate fields for control_unit and the
//  register file, and computes next-PC from control_unit's Branch/Bneq plus the ALU zero flag.
//  Adds stall, halt and a retired-instruction counter.
// PARAMETERS
//  ADDR_W    8        PC / imem address width (word-addressed, 1 word = 1 instruction)
//  RESET_PC  0        PC value loaded on reset
//  HALT_OP   4'b1111  opcode that halts fetch
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  stall        in   1       1 = hold PC and counter this cycle
//  branch       in   1       control_unit Branch (beq)
//  bneq         in   1       control_unit Bneq (bne)
//  zero         in   1       ALU zero flag for current instruction
//  imem_data    in   16      instruction word at imem_addr (combinational read)
//  imem_addr    out  ADDR_W  = pc
//  pc           out  ADDR_W  current PC
//  opcode       out  4       imem_data[15:12] -> control_unit opcode
//  rs, rt, rd   out  3 each  imem_data[11:9], [8:6], [5:3]
//  imm_ext      out  16      sign-extended imem_data[5:0]
//  valid        out  1       ~halted & ~stall; downstream gates RegWrite/MemWrite with it
//  halted       out  1       sticky halt flag
//  instr_count  out  16      retired-instruction count
// BEHAVIOUR
//  - Reset (rst_n=0, async): pc=RESET_PC, halted=0, instr_count=0; valid=~stall after release.
//  - Field outputs purely combinational from imem_data; no fetch latency (single-cycle).
//  - taken = (branch & zero) | (bneq & ~zero); branch & bneq both 1 -> always taken.
//  - next_pc = taken ? pc + 1 + imm_ext[ADDR_W-1:0] : pc + 1; modulo 2^ADDR_W (wrap, no flag).
//  - State: RUN / HALT (halted bit).
//    RUN, stall=1: pc, instr_count hold; opcode HALT_OP ignored until stall drops.
//    RUN, stall=0, opcode!=HALT_OP: pc<=next_pc; instr_count<=instr_count+1 (saturate 16'hFFFF).
//    RUN, stall=0, opcode==HALT_OP: halted<=1, pc holds, instr_count+1 (halt retires);
//      branch/bneq ignored for halt opcode.
//    HALT: pc, instr_count frozen; valid=0; exit only via reset.
//  - Reset asserted mid-operation overrides all; async clear regardless of stall/halt.
//  - imem_data X/unknown not checked; caller guarantees valid memory contents.
// TESTING
//  1 rst_n low then release, stall=0, imem=NOP stream -> pc 0,1,2,3 on successive edges; count=3 after 3 edges.
//  2 pc=5, branch=1, zero=1, imm6=6'd4 -> pc=10; same with zero=0 -> pc=6.
//  3 pc=5, bneq=1, zero=0, imm6=6'b111100 (-4) -> pc=2; zero=1 -> pc=6.
//  4 ADDR_W=8, pc=8'hFF, no branch -> pc=8'h00; pc=1, taken, imm=-4 -> pc=8'hFE.
//  5 stall=1 for 3 cycles at pc=7 -> pc stays 7, count frozen, valid=0; opcode=HALT_OP under stall -> no halt.
//  6 opcode=HALT_OP at pc=9 -> halted=1, pc=9 held, valid=0 forever; rst_n pulse mid-cycle -> pc=0, halted=0 at once.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, instruction field split and next-PC selection.
// Adds stall, sticky halt and a saturating retired-instruction counter.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic              bneq,
    input  logic              zero,
    input  logic [15:0]       imem_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        opcode,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic [15:0]       imm_ext,
    output logic              valid,
    output logic              halted,
    output logic [15:0]       instr_count
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]        state;
    logic              taken;
    logic              is_halt;
    logic              advance;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;

    assign opcode  = imem_data[15:12];
    assign rs      = imem_data[11:9];
    assign rt      = imem_data[8:6];
    assign rd      = imem_data[5:3];
    assign imm_ext = {{10{imem_data[5]}}, imem_data[5:0]};

    // both branch flags set means one of the two conditions always holds
    assign taken   = (branch & zero) | (bneq & ~zero);
    assign pc_inc  = pc + ADDR_W'(1);
    assign next_pc = taken ? pc_inc + imm_ext[ADDR_W-1:0] : pc_inc;

    assign is_halt   = (opcode == HALT_OP);
    assign halted    = (state == HALT);
    assign valid     = ~halted & ~stall;
    assign advance   = (state == RUN) & ~stall;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            state       <= RUN;
            instr_count <= '0;
        end else if (advance) begin
            unique case (1'b1)
                is_halt: state <= HALT;
                default: pc    <= next_pc;
            endcase
            if (instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
        end
    end

endmodule
